// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between the bridge (master) and one register-file completer (slave).
interface apb_slave_regfile_if #(
  parameter int data_size    = 8,
  parameter int address_size = 5
) ();
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [address_size-1:0] paddr;
  logic [data_size-1:0]    pwdata;
  logic [data_size-1:0]    prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB completer backed by num_regs words: fixed wait states, registered pready,
// pslverr on addresses at or above num_regs.
module apb_slave_regfile #(
  parameter int data_size    = 8,
  parameter int address_size = 5,
  parameter int num_regs     = 24,
  parameter int wait_states  = 1
) (
  input  logic               clock,
  input  logic               reset,
  apb_slave_regfile_if.slave apb
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int                AW1         = address_size + 1;
  localparam logic [3:0]        LP_WAIT     = 4'(wait_states);
  localparam logic [AW1-1:0]    LP_NUM_REGS = AW1'(num_regs);

  logic [1:0]              r_state;
  logic [3:0]              r_count;
  logic [address_size-1:0] r_addr;
  logic                    r_write;
  logic [data_size-1:0]    r_wdata;
  logic                    r_pready;
  logic                    r_pslverr;
  logic [data_size-1:0]    r_prdata;
  logic [data_size-1:0]    r_regs [num_regs];

  logic [1:0]              w_state_nxt;
  logic [3:0]              w_count_nxt;
  logic [address_size-1:0] w_addr_nxt;
  logic                    w_write_nxt;
  logic [data_size-1:0]    w_wdata_nxt;
  logic                    w_setup;
  logic                    w_access;
  logic                    w_nxt_in_range;
  logic                    w_cur_in_range;
  logic                    w_nxt_done;
  logic                    w_commit;

  assign w_setup  = apb.psel & ~apb.penable;
  assign w_access = apb.psel & apb.penable;

  // A setup phase is taken from any state: fresh start, restart in WAIT, or back-to-back after DONE.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can leave one unassigned and infer a latch.
    w_state_nxt = ST_IDLE;
    w_count_nxt = r_count;
    w_addr_nxt  = r_addr;
    w_write_nxt = r_write;
    w_wdata_nxt = r_wdata;
    if (w_setup) begin
      w_addr_nxt  = apb.paddr;
      w_write_nxt = apb.pwrite;
      w_wdata_nxt = apb.pwdata;
      w_count_nxt = LP_WAIT;
      w_state_nxt = (LP_WAIT == 4'd0) ? ST_DONE : ST_WAIT;
    end else if (r_state == ST_WAIT && w_access) begin
      w_count_nxt = r_count - 4'd1;
      w_state_nxt = (r_count == 4'd1) ? ST_DONE : ST_WAIT;
    end
  end

  assign w_nxt_in_range = {1'b0, w_addr_nxt} < LP_NUM_REGS;
  assign w_cur_in_range = {1'b0, r_addr} < LP_NUM_REGS;
  assign w_nxt_done     = (w_state_nxt == ST_DONE);
  assign w_commit       = (r_state == ST_DONE) & w_access & r_write & w_cur_in_range;

  // Response outputs are computed one edge early so they appear registered with DONE.
  always_ff @(posedge clock) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_addr    <= '0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_addr    <= w_addr_nxt;
      r_write   <= w_write_nxt;
      r_wdata   <= w_wdata_nxt;
      r_pready  <= w_nxt_done;
      r_pslverr <= w_nxt_done & ~w_nxt_in_range;
      r_prdata  <= (w_nxt_done && !w_write_nxt && w_nxt_in_range) ? r_regs[w_addr_nxt] : '0;
    end
  end

  // NOTE: the storage array is reset explicitly because reads after reset must return 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < num_regs; i++) r_regs[i] <= '0;
    end else if (w_commit) begin
      r_regs[r_addr] <= r_wdata;
    end
  end

  assign apb.prdata  = r_prdata;
  assign apb.pready  = r_pready;
  assign apb.pslverr = r_pslverr;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench for apb_slave_regfile: a zero-wait and a one-wait instance, directed
// scenarios followed by randomized traffic checked against an array model.
module tb_apb_slave_regfile;
  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int NREGS = 24;

  logic clock;
  logic reset;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  apb_slave_regfile_if #(.data_size(DW), .address_size(AW)) bus0 ();
  apb_slave_regfile_if #(.data_size(DW), .address_size(AW)) bus1 ();

  apb_slave_regfile #(.data_size(DW), .address_size(AW), .num_regs(NREGS), .wait_states(0)) dut0 (
    .clock (clock),
    .reset (reset),
    .apb   (bus0)
  );

  apb_slave_regfile #(.data_size(DW), .address_size(AW), .num_regs(NREGS), .wait_states(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .apb   (bus1)
  );

  logic          m_psel  [2];
  logic          m_pen   [2];
  logic          m_pwr   [2];
  logic [AW-1:0] m_addr  [2];
  logic [DW-1:0] m_wdata [2];
  logic          s_rdy   [2];
  logic          s_err   [2];
  logic [DW-1:0] s_rdata [2];

  assign bus0.psel    = m_psel[0];
  assign bus0.penable = m_pen[0];
  assign bus0.pwrite  = m_pwr[0];
  assign bus0.paddr   = m_addr[0];
  assign bus0.pwdata  = m_wdata[0];
  assign bus1.psel    = m_psel[1];
  assign bus1.penable = m_pen[1];
  assign bus1.pwrite  = m_pwr[1];
  assign bus1.paddr   = m_addr[1];
  assign bus1.pwdata  = m_wdata[1];
  assign s_rdy[0]   = bus0.pready;
  assign s_err[0]   = bus0.pslverr;
  assign s_rdata[0] = bus0.prdata;
  assign s_rdy[1]   = bus1.pready;
  assign s_err[1]   = bus1.pslverr;
  assign s_rdata[1] = bus1.prdata;

  typedef struct {
    int            cyc;
    bit            wr;
    logic [DW-1:0] rdata;
    bit            err;
  } exp_t;

  exp_t          q0[$];
  exp_t          q1[$];
  logic [DW-1:0] mem [2][32];
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 32; a++) mem[d][a] = '0;
  endtask

  // One complete transfer with the timing the spec promises; expectations go to the scoreboard.
  task automatic xfer(input int d, input bit wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input bit abort);
    exp_t e;
    @(posedge clock); #1;
    m_psel[d] = 1'b1; m_pen[d] = 1'b0; m_pwr[d] = wr; m_addr[d] = a; m_wdata[d] = wd;
    if (!abort) begin
      e.cyc   = cyc + ws_of(d) + 1;
      e.wr    = wr;
      e.err   = (a >= NREGS);
      e.rdata = (a < NREGS) ? mem[d][a] : '0;
      if (wr && a < NREGS) mem[d][a] = wd;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(posedge clock); #1;
    if (abort) begin
      m_psel[d] = 1'b0; m_pen[d] = 1'b0;
    end else begin
      m_pen[d] = 1'b1;
      repeat (ws_of(d)) @(posedge clock);
    end
  endtask

  task automatic idle(input int d, input int n);
    repeat (n) begin
      @(posedge clock); #1;
      m_psel[d] = 1'b0; m_pen[d] = 1'b0;
    end
  endtask

  task automatic rand_run(input int d);
    bit            wr;
    bit            ab;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    for (int i = 0; i < 150; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = AW'($urandom_range(0, 31));
      wd = DW'($urandom);
      ab = (ws_of(d) > 0) && ($urandom_range(0, 9) == 0);
      xfer(d, wr, a, wd, ab);
      idle(d, $urandom_range(0, 2));
    end
    idle(d, 1);
  endtask

  // Monitor: pready must rise exactly in the cycle the scoreboard head names.
  task automatic mon(input int d);
    exp_t e;
    bit   due;
    due = 1'b0;
    if (d == 0 && q0.size() > 0 && q0[0].cyc == cyc) begin e = q0.pop_front(); due = 1'b1; end
    if (d == 1 && q1.size() > 0 && q1[0].cyc == cyc) begin e = q1.pop_front(); due = 1'b1; end
    check($sformatf("dut%0d pready cyc%0d", d, cyc), s_rdy[d], due);
    if (due) begin
      check($sformatf("dut%0d pslverr cyc%0d", d, cyc), s_err[d], e.err);
      if (!e.wr) check($sformatf("dut%0d prdata cyc%0d", d, cyc), s_rdata[d], e.rdata);
    end else begin
      check($sformatf("dut%0d idle pslverr cyc%0d", d, cyc), s_err[d], 1'b0);
      check($sformatf("dut%0d idle prdata cyc%0d", d, cyc), s_rdata[d], '0);
    end
  endtask

  always @(negedge clock) begin
    if (cyc > 0) begin
      mon(0);
      mon(1);
    end
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    clear_model();
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m_psel[d] = 1'($urandom); m_pen[d] = 1'($urandom); m_pwr[d] = 1'($urandom);
      m_addr[d] = AW'($urandom); m_wdata[d] = DW'($urandom);
    end
    @(posedge clock); #1;
    for (int d = 0; d < 2; d++) begin
      m_psel[d] = 1'($urandom); m_pen[d] = 1'($urandom); m_pwr[d] = 1'($urandom);
      m_addr[d] = AW'($urandom); m_wdata[d] = DW'($urandom);
    end
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d reset pready", d), s_rdy[d], 1'b0);
      check($sformatf("dut%0d reset pslverr", d), s_err[d], 1'b0);
      check($sformatf("dut%0d reset prdata", d), s_rdata[d], '0);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin m_psel[d] = 1'b0; m_pen[d] = 1'b0; end
    @(negedge clock);
    for (int d = 0; d < 2; d++) check($sformatf("dut%0d post-reset pready", d), s_rdy[d], 1'b0);

    xfer(1, 1'b0, 5'd5, '0, 1'b0);          idle(1, 1);
    xfer(1, 1'b1, 5'd3, 8'hA5, 1'b0);       idle(1, 1);
    xfer(1, 1'b0, 5'd3, '0, 1'b0);          idle(1, 1);

    xfer(0, 1'b1, 5'd0, 8'h3C, 1'b0);
    xfer(0, 1'b0, 5'd0, '0, 1'b0);          idle(0, 1);

    xfer(1, 1'b1, 5'd23, 8'h5E, 1'b0);      idle(1, 1);
    xfer(1, 1'b1, 5'd24, 8'hFF, 1'b0);      idle(1, 1);
    xfer(1, 1'b0, 5'd24, '0, 1'b0);         idle(1, 1);
    xfer(1, 1'b0, 5'd23, '0, 1'b0);         idle(1, 1);
    xfer(0, 1'b1, 5'd31, 8'h99, 1'b0);
    xfer(0, 1'b0, 5'd31, '0, 1'b0);         idle(0, 1);

    xfer(1, 1'b1, 5'd7, 8'h5A, 1'b0);       idle(1, 1);
    xfer(1, 1'b1, 5'd7, 8'h77, 1'b1);       idle(1, 2);
    xfer(1, 1'b0, 5'd7, '0, 1'b0);          idle(1, 1);

    xfer(1, 1'b1, 5'd1, 8'h12, 1'b0);
    xfer(1, 1'b1, 5'd2, 8'h34, 1'b0);
    xfer(1, 1'b0, 5'd1, '0, 1'b0);
    xfer(1, 1'b0, 5'd2, '0, 1'b0);          idle(1, 1);

    // Reset lands during the wait cycle of a write; the write must never complete.
    @(posedge clock); #1;
    m_psel[1] = 1'b1; m_pen[1] = 1'b0; m_pwr[1] = 1'b1; m_addr[1] = 5'd4; m_wdata[1] = 8'h11;
    @(posedge clock); #1;
    m_pen[1] = 1'b1; reset = 1'b1;
    @(negedge clock);
    check("mid-reset wait pready", s_rdy[1], 1'b0);
    @(posedge clock); #1;
    reset = 1'b0; m_psel[1] = 1'b0; m_pen[1] = 1'b0;
    clear_model();
    @(negedge clock);
    check("mid-reset no pready", s_rdy[1], 1'b0);
    xfer(1, 1'b0, 5'd4, '0, 1'b0);          idle(1, 1);
    xfer(1, 1'b0, 5'd3, '0, 1'b0);          idle(1, 1);

    fork
      rand_run(0);
      rand_run(1);
    join

    repeat (5) @(posedge clock);
    check("dut0 scoreboard drained", q0.size(), 0);
    check("dut1 scoreboard drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

APB completer that terminates one `pselx` bit of the APB bridge and backs it with a register file of `num_regs` words. It samples the setup phase, inserts a fixed number of wait states, completes each transfer with `pready`, and flags out-of-range addresses with `pslverr`. Each completer instance sits on the bridge's `paddr`/`pwdata`/`pwrite`/`penable` bus and drives its own `prdata`/`pready` back to the bridge.

## Interface
- `data_size`, 8: width of `pwdata`, `prdata` and each register.
- `address_size`, 5: width of `paddr`. Word addressing: one address per register.
- `num_regs`, 24: implemented registers at addresses 0..`num_regs`-1. Must be ≤ 2^`address_size`.
- `wait_states`, 1: number of `pready`=0 access cycles before completion, 0..15.

Ports:
- `clock`, in, 1: rising-edge clock.
- `reset`, in, 1: synchronous, active-high reset.
- `psel`, in, 1: select, one bit of the bridge's `pselx`.
- `penable`, in, 1: access-phase indicator.
- `pwrite`, in, 1: 1 = write, 0 = read.
- `paddr`, in, `address_size`: transfer address.
- `pwdata`, in, `data_size`: write data.
- `prdata`, out, `data_size`: read data, valid only while `pready`=1 on a read.
- `pready`, out, 1: transfer completes in the cycle it is high.
- `pslverr`, out, 1: error response, valid only while `pready`=1.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE:
  - When `psel`=1 and `penable`=0 is sampled, latch `paddr`, `pwrite` and `pwdata`, and load the counter with `wait_states`.
  - If `wait_states`=0, go to DONE. Otherwise go to WAIT.
- WAIT:
  - While `psel`=1 and `penable`=1: decrement the counter. Go to DONE on the edge where the counter reaches 0.
  - `psel`=0 aborts the transfer: return to IDLE with no register change.
  - `psel`=1 with `penable`=0 restarts setup with fresh latches.
- DONE:
  - `pready`=1 is driven from a register.
  - Read: `prdata` = reg[latched addr]. If the address is out of range, `prdata`=0 and `pslverr`=1.
  - Write: reg[latched addr] ← latched `pwdata` at the end of DONE, provided `psel`=1 and `penable`=1. If the address is out of range, nothing is written and `pslverr`=1.
  - Next state after DONE: if `psel`=1 and `penable`=0 is sampled (back-to-back setup), take the latch and enter WAIT or DONE as in IDLE. Otherwise go to IDLE.
- Protocol errors:
  - `penable`=1 in IDLE without a prior setup is ignored: stay in IDLE, no `pready`.
  - Leaving DONE drops `pready`, `pslverr` and `prdata` to 0 regardless of the bus.
- The latched address is compared with `num_regs` at full `address_size` width and unsigned. Registers are never written partially.

## Timing
- On reset, all registers are 0, the state is IDLE, the counter is 0, and `prdata`=0, `pready`=0, `pslverr`=0. Reset overrides everything, including mid-transfer; a transfer in flight is dropped with no write.
- Label the setup cycle S. Access cycles follow at S+1, S+2, …
  - `pready` is 0 in S+1..S+`wait_states`.
  - `pready` is 1 in S+`wait_states`+1 for exactly one cycle.
  - Total transfer length is `wait_states`+2 cycles.
- A write is visible to a read whose setup phase comes after the write's DONE cycle.
- Back-to-back transfers with the next setup immediately after DONE incur no idle cycle.
- `pready` is never combinational from inputs. All outputs change only on rising `clock`.

## Test plan
- Reset: hold `reset`=1 for 2 cycles with random bus activity → `pready`=`pslverr`=`prdata`=0. A subsequent read of address 5 returns 0x00.
- Write then read, `wait_states`=1:
  - Write 0xA5 to address 3 → `pready`=0 in the first access cycle and 1 in the second, `pslverr`=0.
  - Read address 3 → `prdata`=0xA5 in the `pready` cycle.
- Zero wait: `wait_states`=0 instance, write 0x3C to address 0, then read it → `pready`=1 in the first access cycle, data 0x3C, each transfer 2 cycles.
- Out of range:
  - Write 0xFF to address 24 → `pslverr`=1 with `pready`.
  - Read address 24 → `prdata`=0, `pslverr`=1.
  - Read address 23 → unchanged contents, `pslverr`=0.
- Abort and back-to-back:
  - Start a write of 0x77 to address 7, then drop `psel` in the wait cycle → a later read of address 7 returns the old value.
  - Issue writes to addresses 1 and 2 back-to-back with setup right after DONE → both committed, no idle cycle between them.
- Mid-transfer reset: assert `reset` during the WAIT of a write of 0x11 to address 4 → no `pready`, and a read of address 4 returns 0x00.
